// File: rtl/instr_loader_pkg.sv
// Shared types for the instruction-memory loader and its write port.
package instr_loader_pkg;

  localparam int LDR_ADDR_W = 8;
  localparam int LDR_DEPTH  = 256;

  typedef logic [2:0] ldr_state_t;

  localparam ldr_state_t S_IDLE   = 3'd0;
  localparam ldr_state_t S_LEN_HI = 3'd1;
  localparam ldr_state_t S_LEN_LO = 3'd2;
  localparam ldr_state_t S_DAT_HI = 3'd3;
  localparam ldr_state_t S_DAT_LO = 3'd4;
  localparam ldr_state_t S_CHK    = 3'd5;
  localparam ldr_state_t S_DONE   = 3'd6;
  localparam ldr_state_t S_ERR    = 3'd7;

  typedef struct packed {
    logic                  we;
    logic [LDR_ADDR_W-1:0] adr;
    logic [15:0]           data;
  } signal_im_wr;

endpackage

// File: rtl/instr_loader.sv
// Framed byte-stream loader writing 16-bit words into instruction memory.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = LDR_ADDR_W,
  parameter int DEPTH  = LDR_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              load_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_adr_o,
  output logic [15:0]       im_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [16:0] MAX_LEN = 17'(DEPTH);

  ldr_state_t  state_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [7:0]  hi_q;
  logic [7:0]  chk_q;

  logic        acc;
  logic [15:0] len_w;
  logic [15:0] cnt_nxt;

  assign byte_ready_o = state_q inside
    {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK};

  assign acc     = byte_valid_i && byte_ready_o;
  assign len_w   = {len_q[15:8], byte_i};
  assign cnt_nxt = cnt_q + 16'd1;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      im_we_o    <= 1'b0;
      im_adr_o   <= '0;
      im_data_o  <= '0;
      cpu_hold_o <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      im_we_o <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_i) begin
            state_q    <= S_LEN_HI;
            cnt_q      <= '0;
            chk_q      <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            cpu_hold_o <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (acc) begin
            len_q[15:8] <= byte_i;
            chk_q       <= chk_q ^ byte_i;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (acc) begin
            len_q[7:0] <= byte_i;
            chk_q      <= chk_q ^ byte_i;
            // oversize frames are rejected before any word is written
            if (len_w == 16'd0) begin
              state_q <= S_CHK;
            end else if ({1'b0, len_w} > MAX_LEN) begin
              state_q <= S_ERR;
              err_o   <= 1'b1;
            end else begin
              state_q <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (acc) begin
            hi_q    <= byte_i;
            chk_q   <= chk_q ^ byte_i;
            state_q <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          if (acc) begin
            im_we_o   <= 1'b1;
            im_adr_o  <= cnt_q[ADDR_W-1:0];
            im_data_o <= {hi_q, byte_i};
            cnt_q     <= cnt_nxt;
            chk_q     <= chk_q ^ byte_i;
            state_q   <= (cnt_nxt == len_q) ? S_CHK : S_DAT_HI;
          end
        end
        S_CHK: begin
          if (acc) begin
            if (byte_i == chk_q) begin
              state_q    <= S_DONE;
              done_o     <= 1'b1;
              cpu_hold_o <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_o   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Table-driven bench with a write scoreboard for instr_loader.
module tb_instr_loader;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        load_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        im_we_o;
  logic [7:0]  im_adr_o;
  logic [15:0] im_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  adr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b [8];
    int          nwr;
    logic [15:0] wd [2];
    bit          gaps;
    logic        done;
    logic        err;
    logic        hold;
    logic [7:0]  adr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl [6];

  instr_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk_i(clk_i),
    .rst(rst),
    .load_i(load_i),
    .byte_valid_i(byte_valid_i),
    .byte_i(byte_i),
    .byte_ready_o(byte_ready_o),
    .im_we_o(im_we_o),
    .im_adr_o(im_adr_o),
    .im_data_o(im_data_o),
    .cpu_hold_o(cpu_hold_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // write scoreboard
  always @(negedge clk_i) begin
    if (im_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexp_wr: got adr %0h data %0h want none",
                 im_adr_o, im_data_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_adr", 32'(im_adr_o), 32'(e.adr));
        chk("wr_data", 32'(im_data_o), 32'(e.data));
      end
    end
  end

  task automatic pulse_load();
    @(negedge clk_i) load_i = 1'b1;
    @(negedge clk_i) load_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_i) byte_valid_i = 1'b0;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_i       = b;
    n = 0;
    while (byte_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (byte_ready_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ready=%b want 1", byte_ready_o);
      byte_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
    end
  endtask

  task automatic settle();
    @(negedge clk_i) byte_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.adr  = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(byte_ready_o), 0);
    chk({nm, "_we"}, 32'(im_we_o), 0);
    chk({nm, "_adr"}, 32'(im_adr_o), 0);
    chk({nm, "_data"}, 32'(im_data_o), 0);
    chk({nm, "_hold"}, 32'(cpu_hold_o), 1);
    chk({nm, "_done"}, 32'(done_o), 0);
    chk({nm, "_err"}, 32'(err_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"good", 7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD,
               8'h42, 8'h00}, 2, '{16'h1234, 16'hABCD}, 1'b0,
               1'b1, 1'b0, 1'b0, 8'h01, 16'hABCD};
    tbl[1] = '{"zero", 3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 0, '{16'h0, 16'h0}, 1'b0,
               1'b1, 1'b0, 1'b0, 8'h01, 16'hABCD};
    tbl[2] = '{"oversize", 2, '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 0, '{16'h0, 16'h0}, 1'b0,
               1'b0, 1'b1, 1'b1, 8'h01, 16'hABCD};
    tbl[3] = '{"badchk", 7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD,
               8'h43, 8'h00}, 2, '{16'h1234, 16'hABCD}, 1'b0,
               1'b0, 1'b1, 1'b1, 8'h01, 16'hABCD};
    tbl[4] = '{"gaps", 7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD,
               8'h42, 8'h00}, 2, '{16'h1234, 16'hABCD}, 1'b1,
               1'b1, 1'b0, 1'b0, 8'h01, 16'hABCD};
    tbl[5] = '{"one", 5, '{8'h00, 8'h01, 8'hFF, 8'h00, 8'hFE, 8'h00,
               8'h00, 8'h00}, 1, '{16'hFF00, 16'h0}, 1'b1,
               1'b1, 1'b0, 1'b0, 8'h00, 16'hFF00};

    rst          = 1'b1;
    load_i       = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    repeat (3) @(negedge clk_i);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk_i);
    check_reset_vals("idle");

    for (int i = 0; i < 6; i++) begin
      pulse_load();
      for (int w = 0; w < tbl[i].nwr; w++)
        push_wr(8'(w), tbl[i].wd[w]);
      for (int k = 0; k < tbl[i].n; k++)
        send_byte(tbl[i].b[k],
                  tbl[i].gaps ? int'($urandom_range(0, 3)) : 0);
      settle();
      chk({tbl[i].name, "_done"}, 32'(done_o), 32'(tbl[i].done));
      chk({tbl[i].name, "_err"}, 32'(err_o), 32'(tbl[i].err));
      chk({tbl[i].name, "_hold"}, 32'(cpu_hold_o), 32'(tbl[i].hold));
      chk({tbl[i].name, "_ready"}, 32'(byte_ready_o), 0);
      chk({tbl[i].name, "_adr"}, 32'(im_adr_o), 32'(tbl[i].adr));
      chk({tbl[i].name, "_data"}, 32'(im_data_o), 32'(tbl[i].data));
      chk({tbl[i].name, "_pending"}, 32'(exp_q.size()), 0);
      exp_q.delete();
    end

    // load_i pulsed mid-frame must be ignored
    pulse_load();
    push_wr(8'h00, 16'h1234);
    push_wr(8'h01, 16'hABCD);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    @(negedge clk_i) byte_valid_i = 1'b0;
    pulse_load();
    send_byte(8'h34, 1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 2);
    send_byte(8'h42, 0);
    settle();
    chk("midload_done", 32'(done_o), 1);
    chk("midload_hold", 32'(cpu_hold_o), 0);
    chk("midload_pending", 32'(exp_q.size()), 0);
    exp_q.delete();

    // reset after the first word of a frame
    pulse_load();
    push_wr(8'h00, 16'h1234);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk_i) byte_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    chk("midrst_pending", 32'(exp_q.size()), 0);
    @(negedge clk_i) rst = 1'b0;
    pulse_load();
    push_wr(8'h00, 16'h5566);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h32, 0);
    settle();
    chk("afterrst_done", 32'(done_o), 1);
    chk("afterrst_adr", 32'(im_adr_o), 0);
    chk("afterrst_pending", 32'(exp_q.size()), 0);
    exp_q.delete();

    // LEN == DEPTH fills every address
    pulse_load();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < 256; w++) begin
      logic [7:0] h;
      h = 8'(w);
      push_wr(h, {h, ~h});
      send_byte(h, 0);
      send_byte(~h, 0);
    end
    send_byte(8'h01, 0);
    settle();
    chk("full_done", 32'(done_o), 1);
    chk("full_err", 32'(err_o), 0);
    chk("full_adr", 32'(im_adr_o), 32'hFF);
    chk("full_data", 32'(im_data_o), 32'hFF00);
    chk("full_pending", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
